// File: rtl/decim_polyphase_sequencer.sv
// Commutator and sequencer for the Rx polyphase decimator: fans samples out to NPH
// branches, tracks branch latency with a tag pipeline and sums one frame per output.
module decim_polyphase_sequencer #(
    parameter int NPH   = 6,
    parameter int LAT   = 3,
    parameter int IN_W  = 8,
    parameter int BR_W  = 17,
    parameter int ACC_W = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sync_clr,
    input  logic                  in_valid,
    input  logic [IN_W-1:0]       in_data,
    output logic [NPH*IN_W-1:0]   branch_data,
    output logic [NPH-1:0]        phase_en,
    input  logic [NPH*BR_W-1:0]   branch_out,
    output logic                  out_valid,
    output logic [ACC_W-1:0]      out_data
);

    localparam int PH_W = $clog2(NPH);

    typedef struct packed {
        logic            vld;
        logic [PH_W-1:0] ph;
        logic            last;
    } tag_t;

    logic [PH_W-1:0]          ph;
    tag_t                     tags [0:LAT];
    logic signed [BR_W-1:0]   cap_br;
    logic signed [ACC_W-1:0]  cap_ext;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph          <= '0;
            branch_data <= '0;
            phase_en    <= '0;
        end else if (sync_clr) begin
            ph       <= '0;
            phase_en <= '0;
        end else begin
            phase_en <= '0;
            if (in_valid) begin
                for (int unsigned k = 0; k < NPH; k++) begin
                    if (ph == PH_W'(k))
                        branch_data[k*IN_W +: IN_W] <= in_data;
                end
                phase_en <= NPH'(1) << ph;
                ph       <= (ph == PH_W'(NPH-1)) ? '0 : ph + PH_W'(1);
            end
        end
    end

    // Stage 0 is aligned with phase_en; stage LAT lines up with the branch result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LAT + 1; i++)
                tags[i] <= '0;
        end else if (sync_clr) begin
            for (int unsigned i = 0; i < LAT + 1; i++)
                tags[i] <= '0;
        end else begin
            tags[0] <= '{vld: in_valid, ph: ph, last: in_valid && (ph == PH_W'(NPH-1))};
            for (int unsigned i = 1; i < LAT + 1; i++)
                tags[i] <= tags[i-1];
        end
    end

    always_comb begin
        cap_br = '0;
        for (int unsigned k = 0; k < NPH; k++) begin
            if (tags[LAT].ph == PH_W'(k))
                cap_br = branch_out[k*BR_W +: BR_W];
        end
        cap_ext = ACC_W'(cap_br);
        sum     = (tags[LAT].ph == '0) ? cap_ext : acc + cap_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (sync_clr) begin
            acc       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (tags[LAT].vld) begin
                acc <= sum;
                if (tags[LAT].last) begin
                    out_data  <= sum;
                    out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_decim_polyphase_sequencer.sv
// Scoreboard bench: one shared stimulus stream drives two configurations (6/3 and 4/4).
module tb_decim_polyphase_sequencer;

    localparam int IN_W  = 8;
    localparam int BR_W  = 17;
    localparam int ACC_W = 20;

    typedef struct { int cyc; longint data; } out_exp_t;
    typedef struct { int cyc; longint pe; longint bd; } pe_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sync_clr = 1'b0;
    logic in_valid = 1'b0;
    logic [IN_W-1:0] in_data = '0;
    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int NP = (g == 0) ? 6 : 4;
        localparam int LT = (g == 0) ? 3 : 4;

        logic [NP*IN_W-1:0] bd;
        logic [NP-1:0]      pe;
        logic [NP*BR_W-1:0] bo;
        logic               ov;
        logic [ACC_W-1:0]   od;

        decim_polyphase_sequencer #(
            .NPH(NP), .LAT(LT), .IN_W(IN_W), .BR_W(BR_W), .ACC_W(ACC_W)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr),
            .in_valid(in_valid), .in_data(in_data),
            .branch_data(bd), .phase_en(pe), .branch_out(bo),
            .out_valid(ov), .out_data(od)
        );

        // Branch Ek: LT-cycle delay of (held slice k * (k+1)).
        logic signed [BR_W-1:0] pipe [NP][LT];
        always @(posedge clk) begin
            for (int k = 0; k < NP; k++) begin
                pipe[k][0] <= BR_W'(longint'($signed(bd[k*IN_W +: IN_W])) * (k + 1));
                for (int s = 1; s < LT; s++) pipe[k][s] <= pipe[k][s-1];
            end
        end
        always_comb begin
            bo = '0;
            for (int k = 0; k < NP; k++) bo[k*BR_W +: BR_W] = pipe[k][LT-1];
        end

        out_exp_t out_q[$];
        pe_exp_t  pe_q[$];
        int ph_m = 0;
        longint acc_m = 0;
        logic [NP*IN_W-1:0] bd_m = '0;

        // Reference model: frame = NP consecutive accepted samples, result = sum s_k*(k+1).
        always @(posedge clk) begin
            if (!rst_n) begin
                ph_m = 0; acc_m = 0; bd_m = '0;
                out_q.delete(); pe_q.delete();
            end else if (sync_clr) begin
                ph_m = 0; acc_m = 0;
                pe_q.push_back('{cyc + 1, 0, longint'(bd_m)});
                while (out_q.size() > 0 && out_q[$].cyc > cyc) void'(out_q.pop_back());
            end else if (in_valid) begin
                bd_m[ph_m*IN_W +: IN_W] = in_data;
                pe_q.push_back('{cyc + 1, longint'(1) << ph_m, longint'(bd_m)});
                if (ph_m == 0) acc_m = 0;
                acc_m += longint'($signed(in_data)) * (ph_m + 1);
                if (ph_m == NP - 1) out_q.push_back('{cyc + LT + 2, acc_m});
                ph_m = (ph_m + 1) % NP;
            end else begin
                pe_q.push_back('{cyc + 1, 0, longint'(bd_m)});
            end
        end

        longint last_out = 0;
        out_exp_t oe;
        pe_exp_t  px;
        always @(negedge clk) begin
            if (!rst_n) begin
                last_out = 0;
                check($sformatf("i%0d reset out_valid", g), longint'(ov), 0);
                check($sformatf("i%0d reset out_data", g), longint'(od), 0);
                check($sformatf("i%0d reset phase_en", g), longint'(pe), 0);
                check($sformatf("i%0d reset branch_data", g), longint'(bd), 0);
            end else begin
                while (pe_q.size() > 0 && pe_q[0].cyc < cyc) void'(pe_q.pop_front());
                if (pe_q.size() > 0 && pe_q[0].cyc == cyc) begin
                    px = pe_q.pop_front();
                    check($sformatf("i%0d phase_en", g), longint'(pe), px.pe);
                    check($sformatf("i%0d branch_data", g), longint'(bd), px.bd);
                end
                if (ov) begin
                    if (out_q.size() == 0) begin
                        check($sformatf("i%0d spurious out_valid", g), longint'(ov), 0);
                    end else begin
                        oe = out_q.pop_front();
                        check($sformatf("i%0d out_data", g), longint'($signed(od)), oe.data);
                        check($sformatf("i%0d out_valid cycle", g), longint'(cyc), longint'(oe.cyc));
                        last_out = oe.data;
                    end
                end else begin
                    if (out_q.size() > 0 && out_q[0].cyc <= cyc) begin
                        oe = out_q.pop_front();
                        check($sformatf("i%0d missing out_valid", g), longint'(ov), 1);
                        last_out = oe.data;
                    end
                    check($sformatf("i%0d out_data hold", g), longint'($signed(od)), last_out);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [IN_W-1:0] d, input logic clr);
        @(posedge clk);
        #1;
        in_valid = v; in_data = d; sync_clr = clr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0);
    endtask

    task automatic frame_1_to_6(input int gap);
        for (int s = 1; s <= 6; s++) begin
            drive(1'b1, IN_W'(s), 1'b0);
            if (gap > 0) idle(gap);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        frame_1_to_6(0);
        idle(10);
        drive(1'b1, 8'd77, 1'b1);
        for (int i = 0; i < 12; i++) drive(1'b1, 8'h80, 1'b0);
        idle(10);
        drive(1'b0, '0, 1'b1);
        frame_1_to_6(2);
        idle(10);
        drive(1'b0, '0, 1'b1);
        for (int s = 1; s <= 3; s++) drive(1'b1, IN_W'(s * 10), 1'b0);
        drive(1'b1, 8'd99, 1'b1);
        frame_1_to_6(0);
        idle(12);
        for (int i = 0; i < 400; i++) begin
            logic [IN_W-1:0] d;
            d = IN_W'($urandom);
            if ($urandom_range(9) == 0) d = ($urandom_range(1) == 0) ? 8'h80 : 8'h7f;
            drive(($urandom_range(99) < 70), d, ($urandom_range(99) < 3));
        end
        for (int i = 0; i < 4; i++) drive(1'b1, IN_W'($urandom), 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0; in_valid = 1'b0; sync_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        frame_1_to_6(0);
        idle(20);
        check("i0 leftover expected outputs", longint'(gi[0].out_q.size()), 0);
        check("i1 leftover expected outputs", longint'(gi[1].out_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
